// File: rtl/reg_file_pkg.sv
// reg_file_pkg -- shared widths and scan-controller state encoding for the
// register file with debug scan port.
//   REG_W    : register width
//   ADDR_W   : register index width
//   NUM_REGS : number of registers (register 0 is hard-wired to zero)
//   HOLD_W   : hold counter width, wide enough for SCAN_DIV up to 255
package reg_file_pkg;
  localparam int REG_W    = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int HOLD_W   = 8;

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_t;
endpackage

// File: rtl/reg_scan_ctrl.sv
// reg_scan_ctrl -- sequencer for the debug sweep of the register file.
// Presents each register index for SCAN_DIV cycles, 0 through NUM_REGS-1,
// then returns to idle.
//   clk, rst_n  : clock, async active-low reset
//   scan_start  : start a sweep (ignored while one is running)
//   scan_busy   : sweep in progress
//   scan_idx    : register index currently presented
//   scan_valid  : high on the first cycle of each index
//
// state     | meaning
// SCAN_IDLE | no sweep; scan_idx parked at 0
// SCAN_RUN  | sweeping; hold_q counts cycles spent on scan_idx
module reg_scan_ctrl
  import reg_file_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_start,
  output logic              scan_busy,
  output logic [ADDR_W-1:0] scan_idx,
  output logic              scan_valid
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SCAN_DIV - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NUM_REGS - 1);

  scan_state_t       state_q, state_nxt;
  logic [ADDR_W-1:0] idx_q, idx_nxt;
  logic [HOLD_W-1:0] hold_q, hold_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
      hold_q  <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    idx_nxt    = idx_q;
    hold_nxt   = hold_q;
    scan_busy  = 1'b0;
    scan_valid = 1'b0;
    case (state_q)
      SCAN_IDLE: begin
        idx_nxt  = '0;
        hold_nxt = '0;
        if (scan_start) state_nxt = SCAN_RUN;
      end
      SCAN_RUN: begin
        scan_busy  = 1'b1;
        scan_valid = (hold_q == '0);
        if (hold_q == HOLD_LAST) begin
          hold_nxt = '0;
          if (idx_q == IDX_LAST) begin
            state_nxt = SCAN_IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx_q + ADDR_W'(1);
          end
        end else begin
          hold_nxt = hold_q + HOLD_W'(1);
        end
      end
      default: state_nxt = SCAN_IDLE;
    endcase
  end

  assign scan_idx = idx_q;

endmodule

// File: rtl/reg_file_scan.sv
// reg_file_scan -- 32 x 32-bit register file, two combinational read ports,
// one write port, plus a debug scan port that sweeps every register.
//   clk, rst_n           : clock, async active-low reset (clears all registers)
//   R_addr_A, R_addr_B   : read indices -> rdata_A, rdata_B (zero latency)
//   Wt_addr, Wt_data, L_S: write index, data, enable (index 0 is never written)
//   scan_start           : begin a sweep
//   scan_busy, scan_idx,
//   scan_data, scan_valid: sweep status, index, register value, first-cycle strobe
// Build option: define REG_FILE_BYPASS_EN to forward same-cycle write data to
// a read port addressing the register being written. The scan port always
// shows the stored (pre-write) value.
module reg_file_scan
  import reg_file_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] R_addr_A,
  input  logic [ADDR_W-1:0] R_addr_B,
  input  logic [ADDR_W-1:0] Wt_addr,
  input  logic [REG_W-1:0]  Wt_data,
  input  logic              L_S,
  output logic [REG_W-1:0]  rdata_A,
  output logic [REG_W-1:0]  rdata_B,
  input  logic              scan_start,
  output logic              scan_busy,
  output logic [ADDR_W-1:0] scan_idx,
  output logic [REG_W-1:0]  scan_data,
  output logic              scan_valid
);

  logic [REG_W-1:0] regs [NUM_REGS];
  logic             wr_en;
  logic [REG_W-1:0] rd_a_raw, rd_b_raw;

  assign wr_en = L_S && (Wt_addr != '0);

  // regs[0] is held at zero, so every read mux can index the array directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      regs[0] <= '0;
      if (wr_en) regs[Wt_addr] <= Wt_data;
    end
  end

  assign rd_a_raw  = regs[R_addr_A];
  assign rd_b_raw  = regs[R_addr_B];
  assign scan_data = regs[scan_idx];

`ifdef REG_FILE_BYPASS_EN
  assign rdata_A = (wr_en && (Wt_addr == R_addr_A)) ? Wt_data : rd_a_raw;
  assign rdata_B = (wr_en && (Wt_addr == R_addr_B)) ? Wt_data : rd_b_raw;
`else
  assign rdata_A = rd_a_raw;
  assign rdata_B = rd_b_raw;
`endif

  reg_scan_ctrl #(.SCAN_DIV(SCAN_DIV)) u_scan_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_start (scan_start),
    .scan_busy  (scan_busy),
    .scan_idx   (scan_idx),
    .scan_valid (scan_valid)
  );

endmodule

// File: tb/tb_reg_file_scan.sv
module tb_reg_file_scan;
  localparam int SCAN_DIV = 4;
  localparam int NREG     = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  R_addr_A, R_addr_B, Wt_addr;
  logic [31:0] Wt_data;
  logic        L_S;
  logic [31:0] rdata_A, rdata_B;
  logic        scan_start;
  logic        scan_busy;
  logic [4:0]  scan_idx;
  logic [31:0] scan_data;
  logic        scan_valid;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];

  reg_file_scan #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .R_addr_A   (R_addr_A),
    .R_addr_B   (R_addr_B),
    .Wt_addr    (Wt_addr),
    .Wt_data    (Wt_data),
    .L_S        (L_S),
    .rdata_A    (rdata_A),
    .rdata_B    (rdata_B),
    .scan_start (scan_start),
    .scan_busy  (scan_busy),
    .scan_idx   (scan_idx),
    .scan_data  (scan_data),
    .scan_valid (scan_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
    end else begin
      e = sb.pop_front();
      chk(tag, obs, e);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Starts at posedge+1 of the first RUN cycle; c counts cycles since then.
  task automatic sweep(input int restart_at, input int write_at,
                       input logic [31:0] wr_data, input int reset_at,
                       output int busy_cnt, output int valid_cnt);
    busy_cnt  = 0;
    valid_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      scan_start = (c == restart_at);
      if (c == write_at) begin
        L_S     = 1'b1;
        Wt_addr = 5'(c / SCAN_DIV);
        Wt_data = wr_data;
      end else begin
        L_S = 1'b0;
      end
      if (c == reset_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(scan_busy), 32'd0);
        chk("rst_mid_idx", 32'(scan_idx), 32'd0);
        chk("rst_mid_valid", 32'(scan_valid), 32'd0);
        scan_start = 1'b0;
        return;
      end
      @(negedge clk);
      if (!scan_busy) break;
      busy_cnt++;
      if (scan_valid) begin
        valid_cnt++;
        sb_check("scan_idx", 32'(scan_idx));
        sb_check("scan_data", scan_data);
      end
      if (c == write_at) chk("scan_prewrite", scan_data, 32'(c / SCAN_DIV));
      if (write_at >= 0 && c == write_at + 1) chk("scan_postwrite", scan_data, wr_data);
      cycle();
    end
    scan_start = 1'b0;
    L_S        = 1'b0;
  endtask

  initial begin
    int bc, vc, seen;
    rst_n = 1'b0; R_addr_A = '0; R_addr_B = '0; Wt_addr = '0; Wt_data = '0;
    L_S = 1'b0; scan_start = 1'b0;
    #12;
    chk("reset_busy", 32'(scan_busy), 32'd0);
    chk("reset_idx", 32'(scan_idx), 32'd0);
    chk("reset_valid", 32'(scan_valid), 32'd0);
    chk("reset_rdata_A", rdata_A, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // write reg 5, read on both ports
    Wt_addr = 5'd5; Wt_data = 32'hDEADBEEF; L_S = 1'b1; R_addr_A = 5'd5; R_addr_B = 5'd5;
`ifdef REG_FILE_BYPASS_EN
    sb.push_back(32'hDEADBEEF);
`else
    sb.push_back(32'h0);
`endif
    @(negedge clk);
    sb_check("wr5_same_cycle_A", rdata_A);
    cycle();
    L_S = 1'b0;
    sb.push_back(32'hDEADBEEF); sb.push_back(32'hDEADBEEF);
    @(negedge clk);
    sb_check("wr5_rdata_A", rdata_A);
    sb_check("wr5_rdata_B", rdata_B);
    cycle();

    // register 0 ignores writes
    Wt_addr = 5'd0; Wt_data = 32'h12345678; L_S = 1'b1; R_addr_A = 5'd0;
    sb.push_back(32'h0);
    @(negedge clk);
    sb_check("r0_same_cycle", rdata_A);
    cycle();
    L_S = 1'b0;
    sb.push_back(32'h0);
    @(negedge clk);
    sb_check("r0_after_write", rdata_A);
    cycle();

    // reg 7 = 1, then same-cycle write 2 / read
    Wt_addr = 5'd7; Wt_data = 32'd1; L_S = 1'b1;
    cycle();
    Wt_data = 32'd2; R_addr_A = 5'd7; R_addr_B = 5'd7;
`ifdef REG_FILE_BYPASS_EN
    sb.push_back(32'd2);
`else
    sb.push_back(32'd1);
`endif
    @(negedge clk);
    sb_check("r7_same_cycle", rdata_A);
    cycle();
    L_S = 1'b0;
    sb.push_back(32'd2);
    @(negedge clk);
    sb_check("r7_after_write", rdata_B);
    cycle();

    // L_S=0 must not write
    Wt_addr = 5'd9; Wt_data = 32'hFFFF0000; L_S = 1'b0; R_addr_A = 5'd9;
    cycle();
    sb.push_back(32'h0);
    @(negedge clk);
    sb_check("no_write_LS0", rdata_A);
    cycle();

    // reg k = k
    for (int k = 1; k < NREG; k++) begin
      Wt_addr = 5'(k); Wt_data = 32'(k); L_S = 1'b1;
      cycle();
    end
    L_S = 1'b0;
    R_addr_A = 5'd17; R_addr_B = 5'd30;
    sb.push_back(32'd17); sb.push_back(32'd30);
    @(negedge clk);
    sb_check("fill_rdata_A", rdata_A);
    sb_check("fill_rdata_B", rdata_B);
    cycle();

    // sweep 1: plain
    for (int k = 0; k < NREG; k++) begin
      sb.push_back(32'(k)); sb.push_back(32'(k));
    end
    scan_start = 1'b1;
    cycle();
    sweep(-1, -1, 32'h0, -1, bc, vc);
    chk("sweep1_busy_cycles", 32'(bc), 32'd128);
    chk("sweep1_valid_count", 32'(vc), 32'd32);
    chk("sweep1_sb_empty", 32'(sb.size()), 32'd0);
    chk("sweep1_idx_home", 32'(scan_idx), 32'd0);
    cycle();

    // sweep 2: restart request at cycle 50, write to reg 5 at cycle 21
    for (int k = 0; k < NREG; k++) begin
      sb.push_back(32'(k)); sb.push_back(32'(k));
    end
    scan_start = 1'b1;
    cycle();
    sweep(50, 21, 32'hA5A50005, -1, bc, vc);
    chk("sweep2_busy_cycles", 32'(bc), 32'd128);
    chk("sweep2_valid_count", 32'(vc), 32'd32);
    chk("sweep2_sb_empty", 32'(sb.size()), 32'd0);
    cycle();

    // sweep 3: reset at cycle 60
    for (int k = 0; k < 15; k++) begin
      sb.push_back(32'(k));
      sb.push_back(k == 5 ? 32'hA5A50005 : 32'(k));
    end
    scan_start = 1'b1;
    cycle();
    sweep(-1, -1, 32'h0, 60, bc, vc);
    chk("sweep3_valid_before_rst", 32'(vc), 32'd15);
    chk("sweep3_sb_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    L_S = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      R_addr_A = 5'(k); R_addr_B = 5'(NREG - 1 - k);
      sb.push_back(32'h0); sb.push_back(32'h0);
      #1;
      sb_check("post_rst_rdata_A", rdata_A);
      sb_check("post_rst_rdata_B", rdata_B);
    end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (scan_busy) seen++;
    end
    chk("post_rst_no_autostart", 32'(seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_scan.md
REG_FILE_SCAN -- requirements
Module: reg_file_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: clock cycles each register is held on the scan port; legal range 1..255.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port R_addr_A, input, 5: read port A register index.
REQ-005 SHALL have port R_addr_B, input, 5: read port B register index.
REQ-006 SHALL have port Wt_addr, input, 5: write register index, driven by the upstream write-address selector.
REQ-007 SHALL have port Wt_data, input, 32: write data.
REQ-008 SHALL have port L_S, input, 1: write enable.
REQ-009 SHALL have port rdata_A, output, 32: read data for R_addr_A.
REQ-010 SHALL have port rdata_B, output, 32: read data for R_addr_B.
REQ-011 SHALL have port scan_start, input, 1: request a debug sweep of all registers.
REQ-012 SHALL have port scan_busy, output, 1: sweep in progress.
REQ-013 SHALL have port scan_idx, output, 5: index currently presented.
REQ-014 SHALL have port scan_data, output, 32: value of register scan_idx.
REQ-015 SHALL have port scan_valid, output, 1: one-cycle strobe on the first cycle of each index.

Function
REQ-016 SHALL hold 32 x 32-bit registers; register 0 SHALL always read 0 and SHALL never be written.
REQ-017 SHALL write Wt_data to register Wt_addr on the rising clk edge when L_S=1 and Wt_addr!=0.
REQ-018 SHALL drive rdata_A and rdata_B combinationally from the current register contents, with zero added latency.
REQ-019 SHALL allow both read ports to select the same index, with identical results on each.
REQ-020 SHALL implement a scan state machine with states IDLE and RUN.
REQ-021 SHALL leave IDLE for RUN on any cycle where scan_start=1, loading scan_idx=0 and the hold counter=0.
REQ-022 SHALL ignore scan_start while in RUN.
REQ-023 SHALL, in RUN, advance scan_idx after SCAN_DIV cycles at each index, resetting the hold counter on each advance.
REQ-024 SHALL assert scan_valid for exactly the first cycle of each index.
REQ-025 SHALL return to IDLE after the SCAN_DIV-th cycle at index 31; scan_idx SHALL return to 0; each sweep is exactly 32*SCAN_DIV cycles.
REQ-026 SHALL hold scan_busy=1 exactly while in RUN.
REQ-027 SHALL drive scan_data = register[scan_idx] (the pre-write value), combinationally, including on a same-cycle write.
REQ-028 SHALL let register writes continue normally during a sweep.

Reset
REQ-029 SHALL, while rst_n=0, clear registers 1..31 to 0, force IDLE, scan_idx=0, scan_valid=0, scan_busy=0, and the hold counter=0.
REQ-030 SHALL abort any sweep on reset mid-operation; the first sweep after release requires a new scan_start.

Configuration
REQ-031 SHALL support macro REG_FILE_BYPASS_EN: when defined, a read port whose index equals Wt_addr while L_S=1 and Wt_addr!=0 SHALL return Wt_data in the same cycle.
REQ-032 SHALL, without REG_FILE_BYPASS_EN, return the pre-write register value on such reads; the scan port SHALL never bypass.

Structure
REQ-033 SHALL take REG_W=32, ADDR_W=5, NUM_REGS=32 and the scan state encoding from a shared package reg_file_pkg.
REQ-034 SHALL place the scan state machine and hold counter in a sub-module reg_scan_ctrl; the storage array stays in reg_file_scan.

Verification
REQ-035 SHALL pass: write 32'hDEADBEEF to reg 5 with L_S=1 -> next cycle rdata_A=rdata_B=32'hDEADBEEF with R_addr_A=R_addr_B=5.
REQ-036 SHALL pass: write 32'h12345678 to reg 0 -> rdata_A=0 with R_addr_A=0.
REQ-037 SHALL pass: reg 7=1, then same-cycle write of 2 and read of reg 7 -> rdata_A=2 with REG_FILE_BYPASS_EN, 1 without.
REQ-038 SHALL pass, with SCAN_DIV=4 and reg k=k for all k: pulse scan_start -> scan_busy high for 128 cycles, scan_valid pulses 32 times, scan_data=k when scan_idx=k.
REQ-039 SHALL pass: scan_start pulsed again at sweep cycle 50 -> sweep still ends at cycle 128.
REQ-040 SHALL pass: rst_n low at sweep cycle 60 -> immediately scan_busy=0 and scan_idx=0, and all registers read 0 after release.
